// File: rtl/alu_arbiter.sv
// Purpose : two-requester round-robin front end for one shared combinational
//           ALU, with a single registered response slot and per-requester
//           completion counters.
// Latency : one cycle from accept (valid && ready) to o_rsp_valid.
// Backpr. : a response stalled by i_rsp_ready=0 holds its data/id and drops
//           both request readies; a handshake and a new accept may share a
//           cycle, so throughput is one operation per cycle.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_reqN_valid / o_reqN_ready    request handshake per requester (N=0,1)
//   i_reqN_op_a/op_b/alu_op        request operands and ALU op code
//   o_alu_op_a/op_b/o_alu_op       drive to the shared ALU (zero when idle)
//   i_alu_data                     shared ALU result, same cycle
//   o_rsp_valid/i_rsp_ready        response handshake
//   o_rsp_data/o_rsp_id            result and originating requester
//   o_done_cnt0/o_done_cnt1        delivered responses per requester (wrap)
module alu_arbiter #(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  input  logic        i_req1_valid,
  output logic        o_req0_ready,
  output logic        o_req1_ready,
  input  logic [31:0] i_req0_op_a,
  input  logic [31:0] i_req0_op_b,
  input  logic [31:0] i_req1_op_a,
  input  logic [31:0] i_req1_op_b,
  input  logic [3:0]  i_req0_alu_op,
  input  logic [3:0]  i_req1_alu_op,
  output logic [31:0] o_alu_op_a,
  output logic [31:0] o_alu_op_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_id,
  output logic [15:0] o_done_cnt0,
  output logic [15:0] o_done_cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic prio_ptr;   // requester that wins when both are valid
  logic grant_vld;
  logic grant_idx;
  logic slot_free;
  logic accept;
  logic rsp_hs;

  // The slot can take a new result when empty, or when the held result
  // leaves this same cycle.
  assign slot_free = (state == EMPTY) || i_rsp_ready;
  assign rsp_hs    = (state == FULL) && i_rsp_ready;
  assign accept    = grant_vld && slot_free;

  // Grant is suppressed while reset is asserted so readies and the ALU
  // drive read as idle during reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (i_rst_n) begin
      case ({i_req1_valid, i_req0_valid})
        2'b01: begin
          grant_vld = 1'b1;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_idx = prio_ptr;
        end
        default: begin
          grant_vld = 1'b0;
          grant_idx = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; in FULL an accept implies a handshake, so the slot
  // stays FULL and streams back to back.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (rsp_hs && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    o_rsp_valid  = (state == FULL);
    o_req0_ready = accept && (grant_idx == 1'b0);
    o_req1_ready = accept && (grant_idx == 1'b1);
    o_alu_op_a   = 32'd0;
    o_alu_op_b   = 32'd0;
    o_alu_op     = 4'd0;
    if (grant_vld) begin
      if (grant_idx) begin
        o_alu_op_a = i_req1_op_a;
        o_alu_op_b = i_req1_op_b;
        o_alu_op   = i_req1_alu_op;
      end else begin
        o_alu_op_a = i_req0_op_a;
        o_alu_op_b = i_req0_op_b;
        o_alu_op   = i_req0_alu_op;
      end
    end
  end

  // Response payload and round-robin pointer. The payload only moves on
  // accept, so it stays stable under backpressure and after draining.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rsp_data <= 32'd0;
      o_rsp_id   <= 1'b0;
      prio_ptr   <= PRIO_RESET;
    end else if (accept) begin
      o_rsp_data <= i_alu_data;
      o_rsp_id   <= grant_idx;
      prio_ptr   <= ~grant_idx;
    end
  end

  // Completion counters credit the requester of the response leaving now.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_done_cnt0 <= 16'd0;
      o_done_cnt1 <= 16'd0;
    end else if (rsp_hs) begin
      if (o_rsp_id) begin
        o_done_cnt1 <= o_done_cnt1 + 16'd1;
      end else begin
        o_done_cnt0 <= o_done_cnt0 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
  logic [3:0]  req0_alu_op, req1_alu_op;
  logic [31:0] alu_op_a, alu_op_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [15:0] done_cnt0, done_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_RESET(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .i_req0_op_a(req0_op_a), .i_req0_op_b(req0_op_b),
    .i_req1_op_a(req1_op_a), .i_req1_op_b(req1_op_b),
    .i_req0_alu_op(req0_alu_op), .i_req1_alu_op(req1_alu_op),
    .o_alu_op_a(alu_op_a), .o_alu_op_b(alu_op_b), .o_alu_op(alu_op),
    .i_alu_data(alu_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_id(rsp_id),
    .o_done_cnt0(done_cnt0), .o_done_cnt1(done_cnt1)
  );

  // Shared combinational ALU: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR
  // 6 SRL 7 SRA 8 OR 9 AND, anything else returns 0.
  always_comb begin
    case (alu_op)
      4'd0: alu_data = alu_op_a + alu_op_b;
      4'd1: alu_data = alu_op_a - alu_op_b;
      4'd2: alu_data = alu_op_a << alu_op_b[4:0];
      4'd3: alu_data = {31'd0, $signed(alu_op_a) < $signed(alu_op_b)};
      4'd4: alu_data = {31'd0, alu_op_a < alu_op_b};
      4'd5: alu_data = alu_op_a ^ alu_op_b;
      4'd6: alu_data = alu_op_a >> alu_op_b[4:0];
      4'd7: alu_data = $unsigned($signed(alu_op_a) >>> alu_op_b[4:0]);
      4'd8: alu_data = alu_op_a | alu_op_b;
      4'd9: alu_data = alu_op_a & alu_op_b;
      default: alu_data = 32'd0;
    endcase
  end

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op_a = 0; req0_op_b = 0; req0_alu_op = 0;
    req1_op_a = 0; req1_op_b = 0; req1_alu_op = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    req0_valid = 1; req0_op_a = 32'h11; req0_op_b = 32'h22; req0_alu_op = 4'd5;
    req1_valid = 1; req1_op_a = 32'h33; req1_op_b = 32'h44; req1_alu_op = 4'd8;
    rsp_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_readies got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({alu_op_a, alu_op_b, alu_op} !== 68'd0) begin
      errors++; $display("FAIL reset_alu_drive got %h/%h/%h want 0/0/0", alu_op_a, alu_op_b, alu_op);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_id} !== 34'd0) begin
      errors++; $display("FAIL reset_rsp got v=%b d=%h id=%b want 0/0/0", rsp_valid, rsp_data, rsp_id);
    end
    checks++;
    if ({done_cnt0, done_cnt1} !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", done_cnt0, done_cnt1);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL reset_prio got r0r1=%b want 10", {req0_ready, req1_ready});
    end
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_op_a = 5; req0_op_b = 7; req0_alu_op = 4'd0;
    rsp_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
    end
    checks++;
    if (alu_op_a !== 32'd5 || alu_op_b !== 32'd7 || alu_op !== 4'd0) begin
      errors++; $display("FAIL single_alu_drive got %h/%h/%h want 5/7/0", alu_op_a, alu_op_b, alu_op);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL single_rsp got v=%b d=%0d id=%b want 1/12/0", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++;
    if ({alu_op_a, alu_op_b, alu_op, req0_ready} !== 69'd0) begin
      errors++; $display("FAIL idle_drive got %h/%h/%h r0=%b want 0", alu_op_a, alu_op_b, alu_op, req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd12 || done_cnt0 !== 16'd1) begin
      errors++; $display("FAIL single_drain got v=%b d=%0d c0=%0d want 0/12/1", rsp_valid, rsp_data, done_cnt0);
    end
  endtask

  task automatic test_priority();
    do_reset();
    req0_valid = 1; req0_op_a = 10; req0_op_b = 3; req0_alu_op = 4'd1;
    req1_valid = 1; req1_op_a = 1;  req1_op_b = 4; req1_alu_op = 4'd2;
    rsp_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL prio_first got %b want 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd7 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL prio_rsp0 got v=%b d=%0d id=%b want 1/7/0", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL prio_rotate got %b want 01", {req0_ready, req1_ready});
    end
    req0_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd16 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL prio_rsp1 got v=%b d=%0d id=%b want 1/16/1", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
    req1_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (done_cnt0 !== 16'd1 || done_cnt1 !== 16'd1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL prio_counts got c0=%0d c1=%0d v=%b want 1/1/0", done_cnt0, done_cnt1, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1; req1_op_a = 32'h8000_0000; req1_op_b = 31; req1_alu_op = 4'd7;
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_op_a = 1; req0_op_b = 1; req0_alu_op = 4'd0;
    req1_op_a = 2; req1_op_b = 2; req1_alu_op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_id !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%b want 1/ffffffff/1", i, rsp_valid, rsp_data, rsp_id);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_readies[%0d] got %b want 00", i, {req0_ready, req1_ready});
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || done_cnt1 !== 16'd1 || done_cnt0 !== 16'd0) begin
      errors++; $display("FAIL bp_deliver got v=%b c0=%0d c1=%0d want 0/0/1", rsp_valid, done_cnt0, done_cnt1);
    end
    @(posedge clk); #1;
    checks++;
    if (done_cnt1 !== 16'd1) begin
      errors++; $display("FAIL bp_once got c1=%0d want 1", done_cnt1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1; req0_op_a = 100; req0_op_b = 1; req0_alu_op = 4'd0;
    req1_valid = 1; req1_op_a = 200; req1_op_b = 2; req1_alu_op = 4'd0;
    rsp_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== i[0] ||
          rsp_data !== (i[0] ? 32'd202 : 32'd101)) begin
        errors++; $display("FAIL b2b[%0d] got v=%b id=%b d=%0d want 1/%0d/%0d",
                           i, rsp_valid, rsp_id, rsp_data, i % 2, (i % 2) ? 202 : 101);
      end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (done_cnt0 !== 16'd5 || done_cnt1 !== 16'd5) begin
      errors++; $display("FAIL b2b_counts got %0d/%0d want 5/5", done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1; req0_op_a = 1; req0_op_b = 3; req0_alu_op = 4'd4;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin
      errors++; $display("FAIL sltu_rsp got v=%b d=%0d want 1/1", rsp_valid, rsp_data);
    end
    @(negedge clk);
    rst_n = 0;
    req0_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
      errors++; $display("FAIL midrst got v=%b c0=%0d c1=%0d want 0/0/0", rsp_valid, done_cnt0, done_cnt1);
    end
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midrst_prio got %b want 10", {req0_ready, req1_ready});
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    req0_valid = 1; req0_op_a = 3; req0_op_b = 4; req0_alu_op = 4'd0;
    rsp_ready = 1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (done_cnt0 !== 16'hFFFF || rsp_valid !== 1'b0 || rsp_data !== 32'd7) begin
      errors++; $display("FAIL wrap_preload got c0=%h v=%b d=%0d want ffff/0/7", done_cnt0, rsp_valid, rsp_data);
    end
    @(negedge clk);
    req0_valid = 1; req0_op_a = 7; req0_op_b = 9; req0_alu_op = 4'd12;
    #1;
    checks++;
    if (alu_op !== 4'd12 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL op12_forward got op=%0d r0=%b want 12/1", alu_op, req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL op12_rsp got v=%b d=%0d id=%b want 1/0/0", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
    req0_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
      errors++; $display("FAIL wrap_zero got c0=%h c1=%h want 0/0", done_cnt0, done_cnt1);
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
